// File: rtl/epsilon_if.sv
`default_nettype none
// ============================================================================
//  Module      : epsilon_if
//  Description : Epsilon bit-stream handshake bundle. The producer drives the
//                stream bit with its framing flags and a valid qualifier; the
//                consumer answers with ready. A beat is valid & ready.
//  Signals     : epsilon_rsc_dat  stream bit (FIFO head)
//                epsilon_vld      stream bit valid
//                epsilon_rdy      consumer accepts the current bit
//                sop / eop        first / last bit of a sequence (with vld)
//  Revision    : 1.0  initial release
// ============================================================================
interface epsilon_if;
   logic epsilon_rsc_dat;
   logic epsilon_vld;
   logic epsilon_rdy;
   logic sop;
   logic eop;

   modport master (
      output epsilon_rsc_dat,
      output epsilon_vld,
      output sop,
      output eop,
      input  epsilon_rdy
   );

   modport slave (
      input  epsilon_rsc_dat,
      input  epsilon_vld,
      input  sop,
      input  eop,
      output epsilon_rdy
   );
endinterface
`default_nettype wire

// File: rtl/epsilon_source.sv
`default_nettype none
// ============================================================================
//  Module      : epsilon_source
//  Description : Producer of framed epsilon bit sequences (SEQ_LEN bits each)
//                taken either from a von Neumann-debiased raw entropy input or
//                from an internal 16-bit Fibonacci LFSR. A first-word-fall-
//                through FIFO decouples the irregular debiaser rate from the
//                consumer handshake.
//  Ports       : clk, rst      clock / synchronous active-high reset
//                start_i       begin a sequence (honoured only when idle)
//                mode_i        source select sampled on start (0 raw, 1 LFSR)
//                raw_bit_i     raw entropy bit
//                raw_vld_i     raw entropy bit valid
//                eps           stream handshake (master side)
//                busy_o        sequence in progress
//                done_o        one-cycle pulse after the last beat
//                overflow_o    sticky: a debiased bit was dropped (FIFO full)
//  Revision    : 1.0  initial release
// ============================================================================
module epsilon_source #(
   parameter int          SEQ_LEN    = 128,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  wire logic  clk,
   input  wire logic  rst,
   input  wire logic  start_i,
   input  wire logic  mode_i,
   input  wire logic  raw_bit_i,
   input  wire logic  raw_vld_i,
   epsilon_if.master  eps,
   output logic       busy_o,
   output logic       done_o,
   output logic       overflow_o
);

   localparam int CW = $clog2(SEQ_LEN + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] C_SEQ_LEN  = CW'(SEQ_LEN);
   localparam logic [CW-1:0] C_LAST_IDX = CW'(SEQ_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            mode_q;
   logic [CW-1:0]   push_cnt_q;
   logic [CW-1:0]   pop_cnt_q;
   logic            vn_phase_q;
   logic            vn_first_q;
   logic            overflow_q;
   logic [15:0]     lfsr_q;
   logic [AW:0]     wr_ptr_q;
   logic [AW:0]     rd_ptr_q;
   logic            mem_q [FIFO_DEPTH];

   logic w_start, w_empty, w_full, w_vld, w_pop, w_prod_en, w_can_push;
   logic w_lfsr_fb, w_vn_diff, w_push, w_push_bit, w_drop, w_raw_take;

   // Pointers carry one extra wrap bit: equal => empty, only MSB differs => full.
   assign w_empty    = (wr_ptr_q == rd_ptr_q);
   assign w_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign w_start    = (state_q == ST_IDLE) && start_i;
   assign w_vld      = (state_q == ST_RUN) && !w_empty;
   assign w_pop      = w_vld && eps.epsilon_rdy;
   assign w_prod_en  = (state_q == ST_RUN) && (push_cnt_q != C_SEQ_LEN);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_can_push = !w_full || w_pop;

   assign w_lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   // Debiaser: only the second bit of an unequal pair produces output.
   assign w_raw_take = w_prod_en && !mode_q && raw_vld_i;
   assign w_vn_diff  = w_raw_take && vn_phase_q && (raw_bit_i != vn_first_q);

   assign w_push     = w_prod_en && (mode_q ? w_can_push : (w_vn_diff && w_can_push));
   assign w_push_bit = mode_q ? w_lfsr_fb : vn_first_q;
   assign w_drop     = w_vn_diff && !w_can_push;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_i) state_d = ST_RUN;
         ST_RUN:  if (w_pop && (pop_cnt_q == C_LAST_IDX)) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         mode_q     <= 1'b0;
         push_cnt_q <= '0;
         pop_cnt_q  <= '0;
         vn_phase_q <= 1'b0;
         vn_first_q <= 1'b0;
         overflow_q <= 1'b0;
         lfsr_q     <= LFSR_SEED;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         if (w_start) begin
            // LFSR deliberately keeps running state across sequences.
            mode_q     <= mode_i;
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
            vn_phase_q <= 1'b0;
            vn_first_q <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
         end else begin
            if (w_push) begin
               wr_ptr_q   <= wr_ptr_q + (AW+1)'(1);
               push_cnt_q <= push_cnt_q + CW'(1);
            end
            if (w_pop) begin
               rd_ptr_q  <= rd_ptr_q + (AW+1)'(1);
               pop_cnt_q <= pop_cnt_q + CW'(1);
            end
            if (w_push && mode_q) begin
               lfsr_q <= {lfsr_q[14:0], w_lfsr_fb};
            end
            if (w_raw_take) begin
               vn_phase_q <= ~vn_phase_q;
               if (!vn_phase_q) vn_first_q <= raw_bit_i;
            end
            if (w_drop) begin
               overflow_q <= 1'b1;
            end
         end
      end
   end

   // Storage needs no reset: contents are only visible behind the pointers.
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= w_push_bit;
      end
   end

   assign eps.epsilon_vld     = w_vld;
   assign eps.epsilon_rsc_dat = w_vld && mem_q[rd_ptr_q[AW-1:0]];
   assign eps.sop             = w_vld && (pop_cnt_q == '0);
   assign eps.eop             = w_vld && (pop_cnt_q == C_LAST_IDX);
   assign busy_o              = (state_q != ST_IDLE);
   assign done_o              = (state_q == ST_DONE);
   assign overflow_o          = overflow_q;

endmodule
`default_nettype wire
